// File: rtl/operand_mux_pipe.sv
// Operand select mux with a registered 2-entry skid-buffer output stage.
// Out-of-range selects produce a zero operand and raise a sticky error flag.
module operand_mux_pipe #(
  parameter int unsigned WIDTH  = 32,
  parameter int unsigned NUM_IN = 4,
  localparam int unsigned SEL_W = (NUM_IN > 2) ? $clog2(NUM_IN) : 1
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [SEL_W-1:0]        sel,
  input  logic [NUM_IN*WIDTH-1:0] src_bus,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [WIDTH-1:0]        opr,
  output logic [SEL_W-1:0]        opr_sel,
  output logic                    bad_sel,
  input  logic                    clr_err
);

  localparam bit             Pow2    = (NUM_IN == (1 << SEL_W));
  localparam logic [SEL_W:0] NumInW  = (SEL_W + 1)'(NUM_IN);

  typedef enum logic [1:0] {StEmpty, StOne, StFull} state_e;

  state_e             state_q, state_d;
  logic [WIDTH-1:0]   main_opr_q, main_opr_d, skid_opr_q, skid_opr_d;
  logic [SEL_W-1:0]   main_sel_q, main_sel_d, skid_sel_q, skid_sel_d;
  logic               in_ready_q, in_ready_d;
  logic               bad_sel_q, bad_sel_d;
  logic [WIDTH-1:0]   mux_opr;
  logic               sel_bad;
  logic               accept, deliver;

  // Selects with no matching source fall through to the zero default.
  always_comb begin
    mux_opr = '0;
    for (int unsigned i = 0; i < NUM_IN; i++) begin
      if (sel == i[SEL_W-1:0]) mux_opr = src_bus[i*WIDTH +: WIDTH];
    end
  end

  assign sel_bad   = Pow2 ? 1'b0 : ({1'b0, sel} >= NumInW);
  assign out_valid = (state_q != StEmpty);
  assign accept    = in_valid && in_ready_q;
  assign deliver   = out_valid && out_ready;

  always_comb begin
    state_d    = state_q;
    main_opr_d = main_opr_q;
    main_sel_d = main_sel_q;
    skid_opr_d = skid_opr_q;
    skid_sel_d = skid_sel_q;
    unique case (state_q)
      StEmpty: begin
        if (accept) begin
          main_opr_d = mux_opr;
          main_sel_d = sel;
          state_d    = StOne;
        end
      end
      StOne: begin
        if (accept && deliver) begin
          main_opr_d = mux_opr;
          main_sel_d = sel;
        end else if (accept) begin
          skid_opr_d = mux_opr;
          skid_sel_d = sel;
          state_d    = StFull;
        end else if (deliver) begin
          state_d = StEmpty;
        end
      end
      StFull: begin
        if (deliver) begin
          main_opr_d = skid_opr_q;
          main_sel_d = skid_sel_q;
          state_d    = StOne;
        end
      end
      default: state_d = StEmpty;
    endcase
  end

  // Ready is registered off the next state so an accept can never overfill.
  assign in_ready_d = (state_d != StFull);

  // Set has priority over clear.
  always_comb begin
    bad_sel_d = bad_sel_q;
    if (accept && sel_bad) bad_sel_d = 1'b1;
    else if (clr_err)      bad_sel_d = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= StEmpty;
      main_opr_q <= '0;
      main_sel_q <= '0;
      skid_opr_q <= '0;
      skid_sel_q <= '0;
      in_ready_q <= 1'b0;
      bad_sel_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      main_opr_q <= main_opr_d;
      main_sel_q <= main_sel_d;
      skid_opr_q <= skid_opr_d;
      skid_sel_q <= skid_sel_d;
      in_ready_q <= in_ready_d;
      bad_sel_q  <= bad_sel_d;
    end
  end

  assign in_ready = in_ready_q;
  assign opr      = main_opr_q;
  assign opr_sel  = main_sel_q;
  assign bad_sel  = Pow2 ? 1'b0 : bad_sel_q;

endmodule

// File: tb/tb_operand_mux_pipe.sv
// Bench for operand_mux_pipe: NUM_IN=4 and NUM_IN=3 instances driven in lockstep,
// compared every cycle against a 2-deep FIFO model plus directed literal checks.
module tb_operand_mux_pipe;

  typedef struct packed {
    logic [31:0] d;
    logic [1:0]  s;
  } beat_t;

  logic         clk = 1'b0;
  logic         rst_n, in_valid, out_ready, clr_err;
  logic [1:0]   sel;
  logic [127:0] src_bus;

  logic        rdy4, val4, bad4, rdy3, val3, bad3;
  logic [31:0] opr4, opr3;
  logic [1:0]  osel4, osel3;

  int n_vec = 0;
  int n_err = 0;

  beat_t q4[$];
  beat_t q3[$];
  logic  rdy_m    = 1'b0;
  logic  exp_bad3 = 1'b0;
  logic  started  = 1'b0;

  always #5 clk = ~clk;

  operand_mux_pipe #(.WIDTH(32), .NUM_IN(4)) dut4 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(rdy4), .sel(sel),
    .src_bus(src_bus), .out_valid(val4), .out_ready(out_ready), .opr(opr4),
    .opr_sel(osel4), .bad_sel(bad4), .clr_err(clr_err)
  );

  operand_mux_pipe #(.WIDTH(32), .NUM_IN(3)) dut3 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(rdy3), .sel(sel),
    .src_bus(src_bus[95:0]), .out_valid(val3), .out_ready(out_ready), .opr(opr3),
    .opr_sel(osel3), .bad_sel(bad3), .clr_err(clr_err)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic beat_t mk(input logic [127:0] bus, input logic [1:0] s, input int n);
    beat_t b;
    b.s = s;
    b.d = (int'(s) < n) ? bus[s*32 +: 32] : 32'h0;
    return b;
  endfunction

  // Reference: an ordered queue of at most two beats; ready means room after this edge.
  initial begin
    logic acc, del;
    forever begin
      @(posedge clk);
      acc = in_valid && rdy_m;
      del = (q4.size() != 0) && out_ready;
      if (!rst_n) begin
        q4.delete();
        q3.delete();
        rdy_m    = 1'b0;
        exp_bad3 = 1'b0;
      end else begin
        if (acc && sel == 2'd3) exp_bad3 = 1'b1;
        else if (clr_err)       exp_bad3 = 1'b0;
        if (del) begin
          void'(q4.pop_front());
          void'(q3.pop_front());
        end
        if (acc) begin
          q4.push_back(mk(src_bus, sel, 4));
          q3.push_back(mk(src_bus, sel, 3));
        end
        rdy_m = (q4.size() < 2);
      end
      started = 1'b1;
    end
  end

  initial begin
    forever begin
      @(negedge clk);
      if (started) begin
        check("in_ready4", rdy4, rdy_m);
        check("in_ready3", rdy3, rdy_m);
        check("out_valid4", val4, q4.size() != 0);
        check("out_valid3", val3, q3.size() != 0);
        check("bad_sel4", bad4, 1'b0);
        check("bad_sel3", bad3, exp_bad3);
        if (q4.size() != 0) begin
          check("opr4", opr4, q4[0].d);
          check("opr_sel4", osel4, q4[0].s);
        end
        if (q3.size() != 0) begin
          check("opr3", opr3, q3[0].d);
          check("opr_sel3", osel3, q3[0].s);
        end
      end
    end
  end

  initial begin
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1; clr_err = 1'b0;
    sel = 2'd0; src_bus = '0;
    repeat (2) @(negedge clk);
    check("rst_out_valid", val4, 1'b0);
    check("rst_in_ready", rdy4, 1'b0);
    check("rst_opr", opr4, 32'h0);
    check("rst_opr_sel", osel4, 2'd0);
    check("rst_bad_sel", bad3, 1'b0);
    rst_n = 1'b1;
    @(negedge clk);
    check("post_rst_in_ready", rdy4, 1'b1);

    // Basic path
    src_bus = {32'hD3D3D3D3, 32'hD2D2D2D2, 32'hD1D1D1D1, 32'h11111111};
    sel = 2'd2; in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    check("basic_valid", val4, 1'b1);
    check("basic_opr", opr4, 32'hD2D2D2D2);
    check("basic_opr_sel", osel4, 2'd2);
    @(negedge clk);
    check("basic_drained", val4, 1'b0);

    // Back-pressure fills both entries
    out_ready = 1'b0;
    src_bus = {32'h0, 32'h0, 32'hBBBB0001, 32'hAAAA0000};
    sel = 2'd0; in_valid = 1'b1;
    @(negedge clk);
    sel = 2'd1;
    @(negedge clk);
    in_valid = 1'b0;
    check("bp_in_ready_low", rdy4, 1'b0);
    check("bp_hold_a", opr4, 32'hAAAA0000);
    @(negedge clk);
    check("bp_still_a", opr4, 32'hAAAA0000);
    out_ready = 1'b1;
    @(negedge clk);
    check("bp_then_b", opr4, 32'hBBBB0001);
    check("bp_ready_back", rdy4, 1'b1);
    @(negedge clk);
    check("bp_drained", val4, 1'b0);

    // Illegal select on the 3-input instance
    src_bus = {$urandom, $urandom, $urandom, $urandom};
    sel = 2'd3; in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    check("ill_opr_zero", opr3, 32'h0);
    check("ill_opr_sel", osel3, 2'd3);
    check("ill_bad_set", bad3, 1'b1);
    @(negedge clk);
    check("ill_bad_sticky", bad3, 1'b1);
    clr_err = 1'b1;
    @(negedge clk);
    clr_err = 1'b0;
    check("ill_bad_cleared", bad3, 1'b0);
    clr_err = 1'b1; in_valid = 1'b1;
    @(negedge clk);
    clr_err = 1'b0; in_valid = 1'b0;
    check("ill_set_wins", bad3, 1'b1);
    clr_err = 1'b1;
    @(negedge clk);
    clr_err = 1'b0;

    // Throughput: no bubbles once the first beat lands
    out_ready = 1'b1;
    for (int i = 0; i < 100; i++) begin
      src_bus = {$urandom, $urandom, $urandom, $urandom};
      sel = 2'(i % 4); in_valid = 1'b1;
      @(negedge clk);
      check("thr_valid", val4, 1'b1);
      check("thr_ready", rdy4, 1'b1);
    end
    in_valid = 1'b0;
    @(negedge clk);

    // Reset while full discards both entries
    out_ready = 1'b0;
    src_bus = {$urandom, $urandom, $urandom, $urandom};
    sel = 2'd1; in_valid = 1'b1;
    repeat (2) @(negedge clk);
    in_valid = 1'b0;
    check("rr_full", rdy4, 1'b0);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    check("rr_out_valid", val4, 1'b0);
    check("rr_opr", opr4, 32'h0);
    check("rr_in_ready", rdy4, 1'b0);
    out_ready = 1'b1;
    @(negedge clk);
    check("rr_ready_back", rdy4, 1'b1);
    check("rr_no_ghost", val4, 1'b0);

    // Random stress
    for (int i = 0; i < 10000; i++) begin
      in_valid  = 1'($urandom % 2);
      out_ready = 1'($urandom % 2);
      clr_err   = ($urandom % 8) == 0;
      sel       = 2'($urandom % 4);
      src_bus   = {$urandom, $urandom, $urandom, $urandom};
      @(negedge clk);
    end
    in_valid = 1'b0; out_ready = 1'b1; clr_err = 1'b0;
    repeat (4) @(negedge clk);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
